rx_deserializer: RTL and testbench
==================================

RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-004 SHALL have parameter LSB_FIRST, default 1: 1 means first data bit lands in o_Data[0]; 0 means first data bit lands in o_Data[DATA_BITS-1].
REQ-005 i_Pclk  input  1  single system clock; all state on its rising edge.
REQ-006 i_Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_Bclk_En  input  1  one-cycle strobe marking the bit sample point.
REQ-008 i_Enable  input  1  receiver enable.
REQ-009 i_Rx_Serial  input  1  serial line; idle high.
REQ-010 o_Data  output  DATA_BITS  received word, held until accepted.
REQ-011 o_Valid  output  1  o_Data and error flags are valid.
REQ-012 i_Ready  input  1  consumer accepts the word when high while o_Valid is high.
REQ-013 o_Parity_Err  output  1  parity mismatch for the held word.
REQ-014 o_Frame_Err  output  1  a stop bit sampled 0 for the held word.
REQ-015 o_Overrun  output  1  sticky flag: a frame was dropped because the holding register was full.
REQ-016 o_Busy  output  1  high in any state other than IDLE.

Function
REQ-017 i_Rx_Serial SHALL pass through a 2-flop synchroniser; every sample below uses the synchronised bit.
- A line change therefore becomes visible 2 i_Pclk cycles later.
REQ-018 FSM states SHALL be IDLE, DATA, PARITY, STOP, and the FSM SHALL advance only on cycles with i_Bclk_En=1.
REQ-019 IDLE -> DATA SHALL occur on a strobe with i_Enable=1 and a sampled bit of 0 (start bit); the bit counter clears at this transition.
REQ-020 DATA SHALL capture one bit per strobe and move on after DATA_BITS bits:
- to PARITY when PARITY!=0;
- otherwise to STOP.
REQ-021 PARITY SHALL sample one bit and compare it with the XOR of the data bits:
- even mode: the data XOR must equal the parity bit;
- odd mode: the data XOR must equal the inverse of the parity bit;
- a mismatch marks a parity error for the frame.
REQ-022 STOP SHALL sample STOP_BITS bits:
- a 0 on any stop bit sets the frame error and completes the frame immediately;
- otherwise the frame completes on the last stop bit.
REQ-023 On frame completion the FSM SHALL return to IDLE in the same cycle, so a start bit on the very next strobe is accepted.
REQ-024 Commit: on the completion cycle, if the holding register is empty or is being accepted in that same cycle (o_Valid & i_Ready):
- o_Data, o_Parity_Err and o_Frame_Err SHALL load;
- o_Valid SHALL be 1 from the next cycle.
REQ-025 If the holding register is full and not accepted on the completion cycle, the new frame SHALL be discarded, the held word kept, and o_Overrun set.
REQ-026 o_Valid & i_Ready SHALL clear o_Valid next cycle (unless a simultaneous commit occurs) and clear o_Overrun.
REQ-027 i_Enable=0 in any non-IDLE state SHALL abort to IDLE on the next clock, discarding the partial frame without affecting the holding register.
REQ-028 i_Bclk_En asserted on consecutive cycles SHALL be legal; each strobe is one bit.
REQ-029 i_Ready while o_Valid=0 SHALL have no effect.

Reset
REQ-030 While i_Rst_n=0, all state SHALL be forced immediately to its reset value:
- state = IDLE, o_Data = 0, o_Valid = 0, all error flags = 0, o_Busy = 0;
- synchroniser flops = 1.
REQ-031 Reset mid-frame SHALL discard the partial frame, and no o_Valid SHALL appear after release until a complete new frame is received.

Structure
REQ-032 A shared package rx_pkg SHALL hold the FSM state encoding and the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-033 The synchroniser SHALL be a separate sub-module sync_2ff (reset value parameterised, here 1); all other logic SHALL be in rx_deserializer.
REQ-034 Parameter legality SHALL be checked at elaboration, and illegal values SHALL be a fatal error.

Verification
REQ-035 Default parameters: line 0, 0x A5 bits LSB first, then 1 -> o_Data=8'hA5, o_Valid=1, no error flags.
REQ-036 PARITY=1, DATA_BITS=7: frame 7'h55 with parity bit 1 -> o_Data=7'h55, o_Parity_Err=1; the same frame with parity bit 0 -> o_Parity_Err=0.
REQ-037 STOP_BITS=2: 0x3C frame with second stop bit 0 -> o_Frame_Err=1, FSM back in IDLE on that strobe.
REQ-038 Overrun: two frames 0x11, 0x22 with i_Ready=0 -> o_Data=8'h11 and o_Overrun=1; one i_Ready pulse -> o_Valid=0 and o_Overrun=0.
REQ-039 Abort: drop i_Enable after 4 data bits, then send a complete frame 0x0F -> only 0x0F is delivered.
REQ-040 Assert i_Rst_n=0 mid-frame for 1 cycle -> outputs zero at once; a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the serial receive path.
package rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_e;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   localparam int unsigned CNT_W = 4;

   // True when the received parity bit disagrees with the data XOR for the given mode.
   function automatic logic parity_err(input int unsigned mode,
                                       input logic        data_xor,
                                       input logic        par_bit);
      if (mode == PAR_ODD) return (data_xor == par_bit);
      else                 return (data_xor != par_bit);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rx_deserializer.sv
// Strobe-driven serial frame receiver with a single-word holding register.
module rx_deserializer
   import rx_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic                 i_Pclk,
   input  logic                 i_Rst_n,
   input  logic                 i_Bclk_En,
   input  logic                 i_Enable,
   input  logic                 i_Rx_Serial,
   output logic [DATA_BITS-1:0] o_Data,
   output logic                 o_Valid,
   input  logic                 i_Ready,
   output logic                 o_Parity_Err,
   output logic                 o_Frame_Err,
   output logic                 o_Overrun,
   output logic                 o_Busy
);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $fatal(1, "rx_deserializer: DATA_BITS must be 5..9");
   end
   if (PARITY > PAR_ODD) begin : g_bad_parity
      $fatal(1, "rx_deserializer: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $fatal(1, "rx_deserializer: STOP_BITS must be 1 or 2");
   end

   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
   localparam logic             LAST_STOP = (STOP_BITS == 2);

   logic                 rx_s;
   rx_state_e            state, state_nxt;
   logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
   logic [CNT_W-1:0]     wr_idx_c;
   logic [DATA_BITS-1:0] shift_q, shift_nxt;
   logic                 xor_q, xor_nxt;
   logic                 perr_q, perr_nxt;
   logic                 stop_q, stop_nxt;
   logic                 done_c, ferr_c;
   logic                 accept_c;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (i_Pclk),
      .rst_n (i_Rst_n),
      .d     (i_Rx_Serial),
      .q     (rx_s)
   );

   assign accept_c = o_Valid & i_Ready;
   assign wr_idx_c = (LSB_FIRST != 0) ? bit_cnt : (LAST_BIT - bit_cnt);

   // Frame sequencing; a dropped enable overrides any strobe in the same cycle.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_q;
      xor_nxt     = xor_q;
      perr_nxt    = perr_q;
      stop_nxt    = stop_q;
      done_c      = 1'b0;
      ferr_c      = 1'b0;

      if (state != ST_IDLE && !i_Enable) begin
         state_nxt = ST_IDLE;
      end else if (i_Bclk_En) begin
         case (state)
            ST_IDLE: begin
               if (i_Enable && !rx_s) begin
                  state_nxt   = ST_DATA;
                  bit_cnt_nxt = '0;
                  shift_nxt   = '0;
                  xor_nxt     = 1'b0;
                  perr_nxt    = 1'b0;
                  stop_nxt    = 1'b0;
               end
            end
            ST_DATA: begin
               for (int unsigned i = 0; i < DATA_BITS; i++) begin
                  if (wr_idx_c == CNT_W'(i)) shift_nxt[i] = rx_s;
               end
               xor_nxt = xor_q ^ rx_s;
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
            ST_PARITY: begin
               perr_nxt  = parity_err(PARITY, xor_q, rx_s);
               state_nxt = ST_STOP;
            end
            ST_STOP: begin
               if (!rx_s) begin
                  done_c    = 1'b1;
                  ferr_c    = 1'b1;
                  state_nxt = ST_IDLE;
               end else if (stop_q == LAST_STOP) begin
                  done_c    = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  stop_nxt = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State registers and the holding register with overrun tracking.
   always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         shift_q      <= '0;
         xor_q        <= 1'b0;
         perr_q       <= 1'b0;
         stop_q       <= 1'b0;
         o_Data       <= '0;
         o_Valid      <= 1'b0;
         o_Parity_Err <= 1'b0;
         o_Frame_Err  <= 1'b0;
         o_Overrun    <= 1'b0;
         o_Busy       <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         shift_q <= shift_nxt;
         xor_q   <= xor_nxt;
         perr_q  <= perr_nxt;
         stop_q  <= stop_nxt;
         o_Busy  <= (state_nxt != ST_IDLE);

         if (accept_c) begin
            o_Valid   <= 1'b0;
            o_Overrun <= 1'b0;
         end
         if (done_c) begin
            if (!o_Valid || accept_c) begin
               o_Data       <= shift_q;
               o_Parity_Err <= perr_q;
               o_Frame_Err  <= ferr_c;
               o_Valid      <= 1'b1;
            end else begin
               o_Overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_deserializer.sv
// Directed bench for rx_deserializer across four parameter sets sharing one line.
module tb_rx_deserializer;

   logic clk = 1'b0;
   logic rst_n, bclk, enable, rx, ready;

   logic [7:0] d0, d2, d3;
   logic [6:0] d1;
   logic       v0, v1, v2, v3, pe0, pe1, pe2, pe3, fe0, fe1, fe2, fe3;
   logic       ov0, ov1, ov2, ov3, b0, b1, b2, b3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rx_deserializer u_def (
      .i_Pclk(clk), .i_Rst_n(rst_n), .i_Bclk_En(bclk), .i_Enable(enable),
      .i_Rx_Serial(rx), .o_Data(d0), .o_Valid(v0), .i_Ready(ready),
      .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Overrun(ov0), .o_Busy(b0));

   rx_deserializer #(.DATA_BITS(7), .PARITY(1)) u_par (
      .i_Pclk(clk), .i_Rst_n(rst_n), .i_Bclk_En(bclk), .i_Enable(enable),
      .i_Rx_Serial(rx), .o_Data(d1), .o_Valid(v1), .i_Ready(ready),
      .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Overrun(ov1), .o_Busy(b1));

   rx_deserializer #(.STOP_BITS(2)) u_stop2 (
      .i_Pclk(clk), .i_Rst_n(rst_n), .i_Bclk_En(bclk), .i_Enable(enable),
      .i_Rx_Serial(rx), .o_Data(d2), .o_Valid(v2), .i_Ready(ready),
      .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Overrun(ov2), .o_Busy(b2));

   rx_deserializer #(.LSB_FIRST(0)) u_msb (
      .i_Pclk(clk), .i_Rst_n(rst_n), .i_Bclk_En(bclk), .i_Enable(enable),
      .i_Rx_Serial(rx), .o_Data(d3), .o_Valid(v3), .i_Ready(ready),
      .o_Parity_Err(pe3), .o_Frame_Err(fe3), .o_Overrun(ov3), .o_Busy(b3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Line change, let it clear the synchroniser, then one strobe.
   task automatic send_bit(input logic b);
      rx = b;
      repeat (3) @(negedge clk);
      bclk = 1'b1;
      @(negedge clk);
      bclk = 1'b0;
   endtask

   task automatic send_frame(input logic [8:0] d, input int nb, input int np,
                             input logic pb, input logic [1:0] st, input int ns);
      send_bit(1'b0);
      for (int i = 0; i < nb; i++) send_bit(d[i]);
      if (np != 0) send_bit(pb);
      for (int i = 0; i < ns; i++) send_bit(st[i]);
      rx = 1'b1;
   endtask

   task automatic pulse_ready();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   initial begin
      logic [9:0] fast;
      rst_n = 1'b0; bclk = 1'b0; enable = 1'b1; rx = 1'b1; ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values on every instance
      chk("rst_data", {d0, d1, d2, d3}, 32'h0);
      chk("rst_valid", {v0, v1, v2, v3}, 32'h0);
      chk("rst_perr", {pe0, pe1, pe2, pe3}, 32'h0);
      chk("rst_ferr", {fe0, fe1, fe2, fe3}, 32'h0);
      chk("rst_ovr", {ov0, ov1, ov2, ov3}, 32'h0);
      chk("rst_busy", {b0, b1, b2, b3}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic 8N1 frame 0xA5
      send_frame(9'h0A5, 8, 0, 1'b0, 2'b11, 1);
      chk("a5_data", 32'(d0), 32'hA5);
      chk("a5_valid", 32'(v0), 32'h1);
      chk("a5_flags", {pe0, fe0, ov0, b0}, 32'h0);
      pulse_ready();
      chk("a5_accept", 32'(v0), 32'h0);

      // Even parity, 7 data bits: 0x55 has even weight
      do_reset();
      send_frame(9'h055, 7, 1, 1'b1, 2'b11, 1);
      chk("par_bad_data", 32'(d1), 32'h55);
      chk("par_bad_perr", 32'(pe1), 32'h1);
      chk("par_bad_ferr", 32'(fe1), 32'h0);
      pulse_ready();
      send_frame(9'h055, 7, 1, 1'b0, 2'b11, 1);
      chk("par_ok_data", 32'(d1), 32'h55);
      chk("par_ok_perr", 32'(pe1), 32'h0);
      chk("par_ok_valid", 32'(v1), 32'h1);

      // Two stop bits: second stop low is a framing error
      do_reset();
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(1'((8'h3C >> i) & 8'h1));
      send_bit(1'b1);
      chk("stop2_mid_busy", 32'(b2), 32'h1);
      chk("stop2_mid_valid", 32'(v2), 32'h0);
      send_bit(1'b0);
      rx = 1'b1;
      chk("stop2_data", 32'(d2), 32'h3C);
      chk("stop2_ferr", 32'(fe2), 32'h1);
      chk("stop2_idle", 32'(b2), 32'h0);
      pulse_ready();
      do_reset();
      send_frame(9'h03C, 8, 0, 1'b0, 2'b11, 2);
      chk("stop2_ok_ferr", {fe2, v2}, 32'h1);

      // Overrun: second frame dropped while first is held
      do_reset();
      send_frame(9'h011, 8, 0, 1'b0, 2'b11, 1);
      chk("ovr_first", {24'h0, d0}, 32'h11);
      chk("ovr_clear", 32'(ov0), 32'h0);
      send_frame(9'h022, 8, 0, 1'b0, 2'b11, 1);
      chk("ovr_held", 32'(d0), 32'h11);
      chk("ovr_set", {ov0, v0}, 32'h3);
      pulse_ready();
      chk("ovr_after_rdy", {ov0, v0}, 32'h0);

      // Abort after four data bits, then a clean 0x0F
      do_reset();
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      chk("abort_busy_pre", 32'(b0), 32'h1);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", {b0, b3}, 32'h0);
      repeat (2) @(negedge clk);
      enable = 1'b1;
      chk("abort_valid", {v0, v3}, 32'h0);
      send_frame(9'h00F, 8, 0, 1'b0, 2'b11, 1);
      chk("abort_data", 32'(d0), 32'h0F);
      chk("abort_msb_data", 32'(d3), 32'hF0);
      pulse_ready();
      chk("abort_single", 32'(v0), 32'h0);

      // Back-to-back strobes: one bit per cycle
      do_reset();
      fast = {1'b1, 8'hC3, 1'b0};
      bclk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rx = fast[i];
         @(negedge clk);
      end
      rx = 1'b1;
      repeat (3) @(negedge clk);
      bclk = 1'b0;
      chk("fast_data", 32'(d0), 32'hC3);
      chk("fast_valid", {v0, fe0}, 32'h2);

      // Reset mid-frame with a word held
      do_reset();
      send_frame(9'h033, 8, 0, 1'b0, 2'b11, 1);
      chk("mrst_pre_valid", 32'(v0), 32'h1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst_n = 1'b0;
      #1;
      chk("mrst_now", {d0, 5'b0, v0, b0, ov0}, 32'h0);
      rx = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("mrst_no_valid", 32'(v0), 32'h0);
      send_frame(9'h081, 8, 0, 1'b0, 2'b11, 1);
      chk("mrst_data", 32'(d0), 32'h81);
      chk("mrst_valid", {v0, fe0, pe0}, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
